// File: rtl/onehot_prio_mux_pkg.sv
// Shared helpers for the one-hot priority mux.
//   port_vec_t      : widest requester vector the helper handles (MaxPorts bits)
//   lowest_set_bit  : isolates the lowest set bit of a vector (zero in, zero out)
package onehot_prio_mux_pkg;

  localparam int unsigned MaxPorts = 256;

  typedef logic [MaxPorts-1:0] port_vec_t;

  // Zero-extension leaves the lowest set bit in place, so callers may widen,
  // call, then truncate back to their own width.
  function automatic port_vec_t lowest_set_bit(input port_vec_t vec);
    return vec & ~(vec - port_vec_t'(1));
  endfunction

endpackage

// File: rtl/onehot_prio_mux_if.sv
// Bus bundle between N masters' request side and the shared slave port.
//   req    : per-requester request          adv   : advance registered grant
//   a_in   : address-phase payloads         a_out : selected address payload
//   d_in   : data-phase payloads            d_out : data payload selected by gnt_d
//   gnt    : combinational grant            gnt_d : registered grant
//   lock   : grant lock (only when ONEHOT_PRIO_MUX_LOCK_EN is defined)
// master drives the requests and payloads; slave is the mux itself.
interface onehot_prio_mux_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_DATA  = 32
);
  logic [N_PORTS-1:0]        req;
  logic                      adv;
  logic [N_PORTS*W_DATA-1:0] a_in;
  logic [W_DATA-1:0]         a_out;
  logic [N_PORTS-1:0]        gnt;
  logic [N_PORTS-1:0]        gnt_d;
  logic [N_PORTS*W_DATA-1:0] d_in;
  logic [W_DATA-1:0]         d_out;
`ifdef ONEHOT_PRIO_MUX_LOCK_EN
  logic                      lock;

  modport master (output req, adv, a_in, d_in, lock, input a_out, gnt, gnt_d, d_out);
  modport slave  (input req, adv, a_in, d_in, lock, output a_out, gnt, gnt_d, d_out);
`else
  modport master (output req, adv, a_in, d_in, input a_out, gnt, gnt_d, d_out);
  modport slave  (input req, adv, a_in, d_in, output a_out, gnt, gnt_d, d_out);
`endif

endinterface

// File: rtl/ohm_andor_mux.sv
// Combinational one-hot AND-OR mux.
//   in  : N_INPUTS slices of W_INPUT bits, slice i = in[i*W_INPUT +: W_INPUT]
//   sel : select vector; zero gives zero, multi-hot ORs the selected slices
//   out : selected payload
module ohm_andor_mux #(
  parameter int unsigned W_INPUT  = 32,
  parameter int unsigned N_INPUTS = 2
) (
  input  logic [N_INPUTS*W_INPUT-1:0] in,
  input  logic [N_INPUTS-1:0]         sel,
  output logic [W_INPUT-1:0]          out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      out = out | ({W_INPUT{sel[i]}} & in[i*W_INPUT +: W_INPUT]);
    end
  end

endmodule

// File: rtl/onehot_prio_mux.sv
// Strict-priority requester select with one-hot AND-OR payload muxing.
// Lowest-index unmasked requester wins; its address payload passes through
// combinationally. A registered copy of the grant (gnt_d) steers the data-phase mux.
//   clk, rst_n : clock, asynchronous active-low reset (clears gnt_d only)
//   bus        : onehot_prio_mux_if slave modport (req/adv/a_in/d_in in,
//                a_out/gnt/gnt_d/d_out out, lock in when enabled)
// Optional feature macro: ONEHOT_PRIO_MUX_LOCK_EN adds bus.lock, which keeps the
// registered grant in place while its requester is still asking.
module onehot_prio_mux
  import onehot_prio_mux_pkg::*;
#(
  parameter int unsigned        N_PORTS   = 2,
  parameter int unsigned        W_DATA    = 32,
  parameter logic [N_PORTS-1:0] CONN_MASK = {N_PORTS{1'b1}}
) (
  input logic             clk,
  input logic             rst_n,
  onehot_prio_mux_if.slave bus
);

  logic [N_PORTS-1:0] mreq;
  logic [N_PORTS-1:0] gnt_prio;
  logic [N_PORTS-1:0] gnt;
  logic [N_PORTS-1:0] gnt_d_q;

  assign mreq     = bus.req & CONN_MASK;
  assign gnt_prio = N_PORTS'(lowest_set_bit(port_vec_t'(mreq)));

`ifdef ONEHOT_PRIO_MUX_LOCK_EN
  // A locked holder outranks lower indices only while it is still requesting.
  always_comb begin
    gnt = gnt_prio;
    if (bus.lock && (|(gnt_d_q & mreq))) begin
      gnt = gnt_d_q;
    end
  end
`else
  assign gnt = gnt_prio;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d_q <= '0;
    end else if (bus.adv) begin
      gnt_d_q <= gnt;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.gnt_d = gnt_d_q;

  ohm_andor_mux #(
    .W_INPUT  (W_DATA),
    .N_INPUTS (N_PORTS)
  ) u_a_mux (
    .in  (bus.a_in),
    .sel (gnt),
    .out (bus.a_out)
  );

  ohm_andor_mux #(
    .W_INPUT  (W_DATA),
    .N_INPUTS (N_PORTS)
  ) u_d_mux (
    .in  (bus.d_in),
    .sel (gnt_d_q),
    .out (bus.d_out)
  );

endmodule

// File: tb/tb_onehot_prio_mux.sv
// Directed bench for onehot_prio_mux: a 2-port full-mask instance, a 2-port
// instance with requester 0 masked, and a 4-port instance for the sweep and lock cases.
module tb_onehot_prio_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  onehot_prio_mux_if #(.N_PORTS(2), .W_DATA(32)) b2 ();
  onehot_prio_mux_if #(.N_PORTS(2), .W_DATA(32)) bm ();
  onehot_prio_mux_if #(.N_PORTS(4), .W_DATA(32)) b4 ();

  onehot_prio_mux #(.N_PORTS(2), .W_DATA(32)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  onehot_prio_mux #(.N_PORTS(2), .W_DATA(32), .CONN_MASK(2'b10)) dutm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm)
  );

  onehot_prio_mux #(.N_PORTS(4), .W_DATA(32)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n   = 1'b0;
    b2.req  = 2'b11;
    b2.adv  = 1'b1;
    b2.a_in = {32'h0000_BBBB, 32'h0000_AAAA};
    b2.d_in = {32'hDDDD_2222, 32'hCCCC_1111};
    @(posedge clk);
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt_d: got %b want 00", b2.gnt_d);
    end
    n_checks++;
    if (b2.d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_d_out: got %h want 00000000", b2.d_out);
    end
    // Combinational path keeps working while reset is held.
    n_checks++;
    if (b2.gnt !== 2'b01 || b2.a_out !== 32'h0000_AAAA) begin
      n_fail++;
      $display("FAIL reset_comb_path: got gnt=%b a_out=%h want 01/0000aaaa", b2.gnt, b2.a_out);
    end
    b2.adv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    logic [1:0]  reqs  [3] = '{2'b11, 2'b10, 2'b00};
    logic [1:0]  gnts  [3] = '{2'b01, 2'b10, 2'b00};
    logic [31:0] aouts [3] = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h0};
    for (int k = 0; k < 3; k++) begin
      b2.req = reqs[k];
      #1;
      n_checks++;
      if (b2.gnt !== gnts[k] || b2.a_out !== aouts[k]) begin
        n_fail++;
        $display("FAIL priority req=%b: got gnt=%b a_out=%h want %b/%h",
                 reqs[k], b2.gnt, b2.a_out, gnts[k], aouts[k]);
      end
    end
  endtask

  task automatic test_adv();
    @(negedge clk);
    b2.req = 2'b10;
    b2.adv = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b10 || b2.d_out !== 32'hDDDD_2222) begin
      n_fail++;
      $display("FAIL adv_capture: got gnt_d=%b d_out=%h want 10/dddd2222", b2.gnt_d, b2.d_out);
    end
    b2.adv = 1'b0;
    b2.req = 2'b01;
    @(posedge clk);
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b10 || b2.d_out !== 32'hDDDD_2222) begin
      n_fail++;
      $display("FAIL adv_hold: got gnt_d=%b d_out=%h want 10/dddd2222", b2.gnt_d, b2.d_out);
    end
    b2.adv = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b01 || b2.d_out !== 32'hCCCC_1111) begin
      n_fail++;
      $display("FAIL adv_back_to_back: got gnt_d=%b d_out=%h want 01/cccc1111",
               b2.gnt_d, b2.d_out);
    end
  endtask

  task automatic test_async_reset();
    // gnt_d is 01 from the previous task; drop reset between edges.
    @(negedge clk);
    b2.adv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b00 || b2.d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt_d=%b d_out=%h want 00/00000000", b2.gnt_d, b2.d_out);
    end
    #1;
    rst_n  = 1'b1;
    b2.req = 2'b10;
    b2.adv = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (b2.gnt_d !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_reload: got gnt_d=%b want 10", b2.gnt_d);
    end
    b2.adv = 1'b0;
  endtask

  task automatic test_mask();
    bm.a_in = {32'h5555_0001, 32'h4444_0000};
    bm.d_in = {32'h7777_0001, 32'h6666_0000};
    bm.req  = 2'b11;
    bm.adv  = 1'b1;
    #1;
    n_checks++;
    if (bm.gnt !== 2'b10 || bm.a_out !== 32'h5555_0001) begin
      n_fail++;
      $display("FAIL mask_both: got gnt=%b a_out=%h want 10/55550001", bm.gnt, bm.a_out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bm.gnt_d !== 2'b10 || bm.d_out !== 32'h7777_0001) begin
      n_fail++;
      $display("FAIL mask_gnt_d: got gnt_d=%b d_out=%h want 10/77770001", bm.gnt_d, bm.d_out);
    end
    bm.req = 2'b01;
    #1;
    n_checks++;
    if (bm.gnt !== 2'b00 || bm.a_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mask_only_masked: got gnt=%b a_out=%h want 00/00000000", bm.gnt, bm.a_out);
    end
    bm.adv = 1'b0;
  endtask

  task automatic test_sweep4();
    logic [3:0]  exp_g;
    logic [31:0] exp_a;
    for (int s = 0; s < 4; s++) begin
      b4.a_in[s*32 +: 32] = 32'hA000_0000 + 32'(s * 17 + 3);
    end
    for (int r = 0; r < 16; r++) begin
      b4.req = 4'(r);
      exp_g  = 4'b0000;
      exp_a  = 32'h0;
      for (int i = 3; i >= 0; i--) begin
        if (r[i]) begin
          exp_g = 4'b0001 << i;
          exp_a = 32'hA000_0000 + 32'(i * 17 + 3);
        end
      end
      #1;
      n_checks++;
      if (b4.gnt !== exp_g || b4.a_out !== exp_a) begin
        n_fail++;
        $display("FAIL sweep4 req=%b: got gnt=%b a_out=%h want %b/%h",
                 4'(r), b4.gnt, b4.a_out, exp_g, exp_a);
      end
      n_checks++;
      if ($countones(b4.gnt) > 1) begin
        n_fail++;
        $display("FAIL sweep4_onehot req=%b: got gnt=%b want at most one bit", 4'(r), b4.gnt);
      end
    end
  endtask

`ifdef ONEHOT_PRIO_MUX_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    b4.lock = 1'b0;
    b4.req  = 4'b0100;
    b4.adv  = 1'b1;
    @(posedge clk);
    #1;
    b4.adv  = 1'b0;
    b4.req  = 4'b0101;
    b4.lock = 1'b1;
    #1;
    n_checks++;
    if (b4.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_hold: got gnt=%b want 0100", b4.gnt);
    end
    b4.lock = 1'b0;
    #1;
    n_checks++;
    if (b4.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_off: got gnt=%b want 0001", b4.gnt);
    end
    b4.lock = 1'b1;
    b4.req  = 4'b0001;
    #1;
    n_checks++;
    if (b4.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_holder_idle: got gnt=%b want 0001", b4.gnt);
    end
    b4.lock = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bm.req   = '0;
    bm.adv   = 1'b0;
    bm.a_in  = '0;
    bm.d_in  = '0;
    b4.req   = '0;
    b4.adv   = 1'b0;
    b4.a_in  = '0;
    b4.d_in  = '0;
`ifdef ONEHOT_PRIO_MUX_LOCK_EN
    b2.lock  = 1'b0;
    bm.lock  = 1'b0;
    b4.lock  = 1'b0;
`endif
    test_reset();
    test_priority();
    test_adv();
    test_async_reset();
    test_mask();
    test_sweep4();
`ifdef ONEHOT_PRIO_MUX_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
